// File: rtl/cache_set_assoc_latency_pkg.sv
// Shared types and constants for the set-associative read-only cache.
package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam int CNT_W = 32;

  function automatic int tag_width(input int addr_width, input int cache_width_bits);
    return addr_width - cache_width_bits;
  endfunction

endpackage

// File: rtl/cache_set_assoc_latency_if.sv
// Requester-side and memory-side handshake bundles for the cache.
interface cache_req_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DWIDTH     = 16
);
  logic                  addr_in_valid;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  addr_in_ready;
  logic [DWIDTH-1:0]     data_out;

  modport master (output addr_in_valid, addr_in, input addr_in_ready, data_out);
  modport slave  (input addr_in_valid, addr_in, output addr_in_ready, data_out);
endinterface

interface cache_mem_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DWIDTH     = 16
);
  logic                  addr_out_valid;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  addr_out_ready;
  logic [DWIDTH-1:0]     data_in;

  modport master (output addr_out_valid, addr_out, input addr_out_ready, data_in);
  modport slave  (input addr_out_valid, addr_out, output addr_out_ready, data_in);
endinterface

// File: rtl/cache_set_assoc_latency_tag_lookup.sv
// Per-set tag/valid compare across all ways; lowest index wins on both outputs.
module cache_tag_lookup #(
  parameter int WAYS      = 2,
  parameter int WIDX      = 1,
  parameter int TAG_WIDTH = 11
) (
  input  logic [WAYS-1:0][TAG_WIDTH-1:0] i_tags,
  input  logic [WAYS-1:0]                i_valid,
  input  logic [TAG_WIDTH-1:0]           i_tag,
  output logic                           o_hit,
  output logic [WIDX-1:0]                o_hit_way,
  output logic                           o_any_invalid,
  output logic [WIDX-1:0]                o_first_invalid_way
);

  logic [WAYS-1:0] w_match;

  for (genvar g = 0; g < WAYS; g++) begin : g_cmp
    assign w_match[g] = i_valid[g] && (i_tags[g] == i_tag);
  end

  assign o_hit         = |w_match;
  assign o_any_invalid = ~&i_valid;

  // Walk downward so the lowest matching / invalid way is the last assignment.
  always_comb begin
    o_hit_way           = '0;
    o_first_invalid_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_match[w]) o_hit_way = WIDX'(w);
      if (!i_valid[w]) o_first_invalid_way = WIDX'(w);
    end
  end

endmodule

// File: rtl/cache_set_assoc_latency.sv
// N-way set-associative read-only cache, round-robin replacement, 1-cycle hit latency.
// Optional hit/miss counters are enabled with `define CACHE_PERF_COUNTERS_EN.
module cache_set_assoc_latency
  import cache_pkg::*;
#(
  parameter int DWIDTH           = 16,
  parameter int ADDR_WIDTH       = 16,
  parameter int CACHE_WIDTH_BITS = 5,
  parameter int WAYS_BITS        = 1
) (
  input  logic          clk,
  input  logic          reset,
  cache_req_if.slave    req,
  cache_mem_if.master   mem
`ifdef CACHE_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
`endif
);

  localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, CACHE_WIDTH_BITS);
  localparam int SETS      = 1 << CACHE_WIDTH_BITS;
  localparam int WAYS      = 1 << WAYS_BITS;
  localparam int WIDX      = (WAYS_BITS > 0) ? WAYS_BITS : 1;

  state_t r_state, w_state_n;

  logic [ADDR_WIDTH-1:0]                r_addr;
  logic [SETS-1:0][WAYS-1:0]            r_valid;
  logic [WAYS-1:0][TAG_WIDTH-1:0]       r_tag [SETS];
  logic [SETS-1:0][WIDX-1:0]            r_rr;
  logic                                 r_hit_acc;
  logic [WIDX-1:0]                      r_hit_way;
  logic [DWIDTH-1:0]                    r_dout;
  logic [WAYS-1:0][DWIDTH-1:0]          w_rd;

  logic [ADDR_WIDTH-1:0]       w_lk_addr;
  logic [CACHE_WIDTH_BITS-1:0] w_lk_set, w_fill_set, w_rd_set;
  logic [TAG_WIDTH-1:0]        w_lk_tag, w_fill_tag;
  logic                        w_hit, w_any_inv;
  logic [WIDX-1:0]             w_hit_way, w_first_inv, w_victim, w_rr_next;
  logic                        w_ready, w_aov, w_hit_acc, w_latch, w_wr_en;

  // Outside S_IDLE the lookup looks at the latched miss line, which yields the fill victim.
  assign w_lk_addr  = (r_state == S_IDLE) ? req.addr_in : r_addr;
  assign w_lk_set   = w_lk_addr[CACHE_WIDTH_BITS-1:0];
  assign w_lk_tag   = w_lk_addr[ADDR_WIDTH-1:CACHE_WIDTH_BITS];
  assign w_fill_set = r_addr[CACHE_WIDTH_BITS-1:0];
  assign w_fill_tag = r_addr[ADDR_WIDTH-1:CACHE_WIDTH_BITS];
  assign w_rd_set   = req.addr_in[CACHE_WIDTH_BITS-1:0];

  cache_tag_lookup #(
    .WAYS      (WAYS),
    .WIDX      (WIDX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_lookup (
    .i_tags              (r_tag[w_lk_set]),
    .i_valid             (r_valid[w_lk_set]),
    .i_tag               (w_lk_tag),
    .o_hit               (w_hit),
    .o_hit_way           (w_hit_way),
    .o_any_invalid       (w_any_inv),
    .o_first_invalid_way (w_first_inv)
  );

  assign w_victim  = w_any_inv ? w_first_inv : r_rr[w_fill_set];
  assign w_rr_next = (r_rr[w_fill_set] == WIDX'(WAYS - 1)) ? '0
                                                           : r_rr[w_fill_set] + WIDX'(1);

  always_comb begin
    w_state_n = r_state;
    w_ready   = 1'b0;
    w_aov     = 1'b0;
    w_hit_acc = 1'b0;
    w_latch   = 1'b0;
    w_wr_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req.addr_in_valid) begin
          if (w_hit) begin
            w_ready   = 1'b1;
            w_hit_acc = 1'b1;
          end else begin
            w_latch   = 1'b1;
            w_state_n = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        w_aov = 1'b1;
        if (mem.addr_out_ready) begin
          w_ready   = 1'b1;
          w_state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        w_wr_en   = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_valid   <= '0;
      r_rr      <= '0;
      r_hit_acc <= 1'b0;
      r_hit_way <= '0;
      r_dout    <= '0;
    end else begin
      r_state   <= w_state_n;
      r_hit_acc <= w_hit_acc;
      r_hit_way <= w_hit_way;
      if (w_latch) r_addr <= req.addr_in;
      if (w_wr_en) begin
        r_valid[w_fill_set][w_victim] <= 1'b1;
        r_rr[w_fill_set]              <= w_rr_next;
      end
      if (r_hit_acc) r_dout <= w_rd[r_hit_way];
      else if (r_state == S_WRITE) r_dout <= mem.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) r_tag[w_fill_set][w_victim] <= w_fill_tag;
  end

  // One RAM per way; every way of the addressed set is read each cycle.
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    logic [DWIDTH-1:0] r_ram [SETS];
    logic [DWIDTH-1:0] r_rd;
    always_ff @(posedge clk) begin
      if (w_wr_en && !reset && (w_victim == WIDX'(g))) r_ram[w_fill_set] <= mem.data_in;
      r_rd <= r_ram[w_rd_set];
    end
    assign w_rd[g] = r_rd;
  end

  assign req.addr_in_ready = w_ready;
  assign req.data_out      = (r_state == S_WRITE) ? mem.data_in
                           : (r_hit_acc ? w_rd[r_hit_way] : r_dout);
  assign mem.addr_out_valid = w_aov;
  assign mem.addr_out       = r_addr;

`ifdef CACHE_PERF_COUNTERS_EN
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_acc && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (w_latch && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule
